// File: rtl/hqm_list_sel_rf_pg_pkg.sv
// Shared constants and power-FSM state encoding for the list-select RF power-gating controller.
package hqm_list_sel_rf_pg_pkg;

    localparam int RF_DEPTH = 4;
    localparam int RF_AW    = 2;
    localparam int RF_DW    = 72;
    localparam int RF_MW    = 73;

    typedef logic [2:0] pg_state_t;

    localparam pg_state_t ST_OFF     = 3'd0;
    localparam pg_state_t ST_PUP     = 3'd1;
    localparam pg_state_t ST_ISO_REL = 3'd2;
    localparam pg_state_t ST_ON      = 3'd3;
    localparam pg_state_t ST_PDN     = 3'd4;

endpackage

// File: rtl/hqm_list_sel_rf_pg_seq.sv
// Power sequencer: OFF/PUP/ISO_REL/ON/PDN with idle-timeout power-down; controls are decoded from state.
// Requests are only accepted in ON; anything else holds req_ready low until the RF is powered and de-isolated.
module hqm_list_sel_rf_pg_seq
    import hqm_list_sel_rf_pg_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_pg_en,
    input  logic req_v,
    input  logic rd_busy,
    input  logic pwr_enable_b_out,
    output logic req_ready,
    output logic pgcb_isol_en,
    output logic pwr_enable_b_in,
    output logic pwr_on
);

    localparam logic [7:0] IDLE_MAX = 8'(IDLE_TIMEOUT - 1);

    pg_state_t  state;
    pg_state_t  state_nxt;
    logic [7:0] idle_cnt;
    logic       pdn_first;
    logic       accept;
    logic       idle_hit;

    assign accept   = req_v & req_ready;
    assign idle_hit = (idle_cnt == IDLE_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:     if (req_v) state_nxt = ST_PUP;
            ST_PUP:     if (!pwr_enable_b_out) state_nxt = ST_ISO_REL;
            ST_ISO_REL: state_nxt = ST_ON;
            ST_ON:      if (idle_hit && cfg_pg_en && !req_v && !rd_busy) state_nxt = ST_PDN;
            // the echo is still low during the isolate-only cycle, so ignore it there
            ST_PDN:     if (!pdn_first && pwr_enable_b_out) state_nxt = ST_OFF;
            default:    state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            pdn_first <= 1'b0;
            idle_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            pdn_first <= (state == ST_ON) && (state_nxt == ST_PDN);
            if ((state != ST_ON) || accept || rd_busy) begin
                idle_cnt <= 8'd0;
            end else if (!idle_hit) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

    assign req_ready       = (state == ST_ON);
    assign pwr_on          = (state == ST_ON);
    assign pgcb_isol_en    = !((state == ST_ISO_REL) || (state == ST_ON));
    assign pwr_enable_b_in = (state == ST_OFF) || ((state == ST_PDN) && !pdn_first);

endmodule

// File: rtl/hqm_list_sel_rf_pg_ctrl.sv
// Power-gated 4x72 RF front end: request->mem port 1 cycle, read data 3 cycles; no response back-pressure.
// Optional parity with HQM_LIST_SEL_RF_PG_CTRL_PAR_EN; req_ready low outside ON holds the client.
module hqm_list_sel_rf_pg_ctrl
    import hqm_list_sel_rf_pg_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_pg_en,
    input  logic             req_v,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [RF_AW-1:0] req_addr,
    input  logic [RF_DW-1:0] req_wdata,
    output logic             rd_v,
    output logic [RF_DW-1:0] rd_data,
    output logic             rd_par_err,
    output logic             mem_we,
    output logic [RF_AW-1:0] mem_waddr,
    output logic [RF_MW-1:0] mem_wdata,
    output logic             mem_re,
    output logic [RF_AW-1:0] mem_raddr,
    input  logic [RF_MW-1:0] mem_rdata,
    output logic             pgcb_isol_en,
    output logic             pwr_enable_b_in,
    input  logic             pwr_enable_b_out,
    output logic             pwr_on
);

    logic accept;
    logic rd_p2;
    logic wpar;
    logic perr;

    assign accept = req_v & req_ready;

    hqm_list_sel_rf_pg_seq #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_seq (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_pg_en        (cfg_pg_en),
        .req_v            (req_v),
        .rd_busy          (mem_re | rd_p2),
        .pwr_enable_b_out (pwr_enable_b_out),
        .req_ready        (req_ready),
        .pgcb_isol_en     (pgcb_isol_en),
        .pwr_enable_b_in  (pwr_enable_b_in),
        .pwr_on           (pwr_on)
    );

`ifdef HQM_LIST_SEL_RF_PG_CTRL_PAR_EN
    assign wpar = ^req_wdata;
    assign perr = ^mem_rdata;
`else
    logic unused_par_bit;
    assign unused_par_bit = mem_rdata[RF_MW-1];
    assign wpar = 1'b0;
    assign perr = 1'b0;
`endif

    // one request per cycle drives exactly one of the two ports, so we/re stay exclusive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_waddr  <= '0;
            mem_raddr  <= '0;
            mem_wdata  <= '0;
            rd_p2      <= 1'b0;
            rd_v       <= 1'b0;
            rd_data    <= '0;
            rd_par_err <= 1'b0;
        end else begin
            mem_we <= accept & req_we;
            mem_re <= accept & ~req_we;
            if (accept && req_we) begin
                mem_waddr <= req_addr;
                mem_wdata <= {wpar, req_wdata};
            end
            if (accept && !req_we) begin
                mem_raddr <= req_addr;
            end
            rd_p2      <= mem_re;
            rd_v       <= rd_p2;
            rd_par_err <= rd_p2 & perr;
            if (rd_p2) begin
                rd_data <= mem_rdata[RF_DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hqm_list_sel_rf_pg_ctrl.sv
// Bench for hqm_list_sel_rf_pg_ctrl: RF and power-chain environment, scoreboard of reads, power sequence timing.
module tb_hqm_list_sel_rf_pg_ctrl;

    localparam int IDLE_TIMEOUT = 16;
    localparam int ECHO_DLY     = 3;
`ifdef HQM_LIST_SEL_RF_PG_CTRL_PAR_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_pg_en = 1'b0;
    logic        req_v = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [71:0] req_wdata = 72'd0;
    logic        req_ready;
    logic        rd_v;
    logic [71:0] rd_data;
    logic        rd_par_err;
    logic        mem_we;
    logic [1:0]  mem_waddr;
    logic [72:0] mem_wdata;
    logic        mem_re;
    logic [1:0]  mem_raddr;
    logic [72:0] mem_rdata = 73'd0;
    logic        pgcb_isol_en;
    logic        pwr_enable_b_in;
    logic        pwr_enable_b_out;
    logic        pwr_on;

    hqm_list_sel_rf_pg_ctrl #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_pg_en        (cfg_pg_en),
        .req_v            (req_v),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rd_v             (rd_v),
        .rd_data          (rd_data),
        .rd_par_err       (rd_par_err),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .mem_re           (mem_re),
        .mem_raddr        (mem_raddr),
        .mem_rdata        (mem_rdata),
        .pgcb_isol_en     (pgcb_isol_en),
        .pwr_enable_b_in  (pwr_enable_b_in),
        .pwr_enable_b_out (pwr_enable_b_out),
        .pwr_on           (pwr_on)
    );

    always #5 clk = ~clk;

    // environment: RF macro with 1-cycle read, power chain echoing enable after ECHO_DLY cycles
    logic [72:0]         rf [4] = '{default: '0};
    logic [ECHO_DLY-1:0] echo_sr = '1;
    logic                corrupt = 1'b0;
    assign pwr_enable_b_out = echo_sr[ECHO_DLY-1];

    always @(posedge clk) begin
        echo_sr <= {echo_sr[ECHO_DLY-2:0], pwr_enable_b_in};
        if (mem_we) rf[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= rf[mem_raddr] ^ {72'd0, corrupt};
    end

    typedef struct {
        logic [71:0] d;
        logic        pe;
        int          due;
    } rd_exp_t;

    rd_exp_t     rdq [$];
    logic [71:0] shadow [4] = '{default: '0};
    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    logic        pend_we = 1'b0;
    logic        pend_re = 1'b0;
    logic [1:0]  pend_addr = 2'd0;
    logic [72:0] pend_wdata = 73'd0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {120'd0, pwr_enable_b_in, pgcb_isol_en, req_ready, pwr_on,
                            rd_v, rd_par_err, mem_we, mem_re}, 128'b1100_0000);
        chk({tag, "_rd_data"}, {56'd0, rd_data}, 128'd0);
        chk({tag, "_mem_addr"}, {124'd0, mem_waddr, mem_raddr}, 128'd0);
        chk({tag, "_mem_wdata"}, {55'd0, mem_wdata}, 128'd0);
    endtask

    // One ON cycle: check this cycle's outputs against the model, then present the next request.
    task automatic step(input logic v, input logic we, input logic [1:0] a, input logic [71:0] d);
        rd_exp_t e;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            e = rdq.pop_front();
            chk("rd_v", {127'd0, rd_v}, 128'd1);
            chk("rd_data", {56'd0, rd_data}, {56'd0, e.d});
            chk("rd_par_err", {127'd0, rd_par_err}, {127'd0, e.pe});
        end else begin
            chk("rd_v_idle", {127'd0, rd_v}, 128'd0);
        end
        chk("mem_we_re", {126'd0, mem_we, mem_re}, {126'd0, pend_we, pend_re});
        if (pend_we) begin
            chk("mem_waddr", {126'd0, mem_waddr}, {126'd0, pend_addr});
            chk("mem_wdata", {55'd0, mem_wdata}, {55'd0, pend_wdata});
        end
        if (pend_re) chk("mem_raddr", {126'd0, mem_raddr}, {126'd0, pend_addr});
        chk("req_ready_on", {127'd0, req_ready}, 128'd1);
        req_v = v; req_we = we; req_addr = a; req_wdata = d;
        pend_we = v && we;
        pend_re = v && !we;
        pend_addr = a;
        pend_wdata = {PAR_EN ? ^d : 1'b0, d};
        if (v && we) shadow[a] = d;
        if (v && !we) begin
            e.d   = shadow[a] ^ {71'd0, corrupt};
            e.pe  = PAR_EN && corrupt;
            e.due = cyc + 3;
            rdq.push_back(e);
        end
        tick();
    endtask

    task automatic wait_on(output int n, output int iso);
        n = 0;
        iso = 0;
        while (!pwr_on && n < 60) begin
            chk("rdy_low", {127'd0, req_ready}, 128'd0);
            if (!pgcb_isol_en) iso++;
            tick();
            n++;
        end
        chk("reached_on", {127'd0, pwr_on}, 128'd1);
    endtask

    initial begin
        int n;
        int iso;
        logic [95:0] rnd;
        logic [71:0] dsave;

        repeat (3) tick();
        check_reset("rst");

        // power-up from reset with a pending write
        rst_n = 1'b1;
        req_v = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 72'h5A;
        tick();
        chk("pup_ctl", {125'd0, pwr_enable_b_in, pgcb_isol_en, req_ready}, 128'b010);
        wait_on(n, iso);
        chk("pup_cycles", n, ECHO_DLY + 2);
        chk("iso_rel_cycles", iso, 1);
        step(1'b1, 1'b1, 2'd1, 72'h5A);

        // back-to-back write and read of the same entry
        step(1'b1, 1'b1, 2'd2, 72'hABC);
        step(1'b1, 1'b0, 2'd2, 72'd0);
        step(1'b1, 1'b1, 2'd0, 72'h123456789ABCDEF012);
        step(1'b1, 1'b1, 2'd3, 72'hFF_0000_0000_0000_00FF);
        step(1'b1, 1'b0, 2'd1, 72'd0);

        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), rnd[71:0]);
        end
        repeat (4) step(1'b0, 1'b0, 2'd0, 72'd0);

        // single-bit read corruption
        step(1'b1, 1'b1, 2'd0, 72'h1);
        repeat (3) step(1'b0, 1'b0, 2'd0, 72'd0);
        corrupt = 1'b1;
        step(1'b1, 1'b0, 2'd0, 72'd0);
        step(1'b0, 1'b0, 2'd0, 72'd0);
        corrupt = 1'b0;
        repeat (4) step(1'b0, 1'b0, 2'd0, 72'd0);

        // power gating disabled: long idle keeps the RF up
        repeat (20) step(1'b0, 1'b0, 2'd0, 72'd0);
        chk("pg_dis_stays_on", {127'd0, pwr_on}, 128'd1);

        // enabling with the idle counter saturated: the concurrent request blocks power-down
        cfg_pg_en = 1'b1;
        step(1'b1, 1'b1, 2'd3, 72'h77);
        n = 0;
        while (pwr_on && n < 100) begin
            step(1'b0, 1'b0, 2'd0, 72'd0);
            n++;
        end
        chk("idle_cycles", n, IDLE_TIMEOUT);
        chk("pdn_first_ctl", {125'd0, pwr_enable_b_in, pgcb_isol_en, req_ready}, 128'b010);
        rnd = {$urandom(), $urandom(), $urandom()};
        dsave = rnd[71:0];
        req_v = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = dsave;
        tick();
        chk("pdn_off_ctl", {125'd0, pwr_enable_b_in, pgcb_isol_en, req_ready}, 128'b110);
        wait_on(n, iso);
        chk("pdn_to_on_cycles", n, 2 * ECHO_DLY + 4);
        chk("pdn_iso_rel_cycles", iso, 1);
        step(1'b1, 1'b1, 2'd0, dsave);
        step(1'b1, 1'b0, 2'd0, 72'd0);
        repeat (4) step(1'b0, 1'b0, 2'd0, 72'd0);
        chk("rdq_drained", rdq.size(), 0);

        // reset one cycle after a read is accepted
        step(1'b1, 1'b0, 2'd3, 72'd0);
        rst_n = 1'b0;
        req_v = 1'b0;
        #1;
        check_reset("mid_rst");
        rdq.delete();
        pend_we = 1'b0;
        pend_re = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (rd_v || pwr_on) n++;
        end
        chk("no_rd_after_rst", n, 0);
        check_reset("post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hqm_list_sel_rf_pg_ctrl.md
HQM_LIST_SEL_RF_PG_CTRL -- requirements
Module: hqm_list_sel_rf_pg_ctrl

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 16: idle cycles in ON before power-down; legal range 2..255.
REQ-002 clk  in  1  the single block clock; all logic is in this domain.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cfg_pg_en  in  1  power-gating enable; 0 keeps the RF powered once up.
REQ-005 req_v / req_ready  in / out  1 / 1  client request handshake; transfer when both are 1.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  2  RF entry.
REQ-008 req_wdata  in  72  write payload.
REQ-009 rd_v  out  1  read response valid; one-cycle pulse, no back-pressure.
REQ-010 rd_data  out  72  read payload.
REQ-011 rd_par_err  out  1  parity error qualifying rd_v.
REQ-012 mem_we, mem_waddr[1:0], mem_wdata[72:0]  out  RF write port.
REQ-013 mem_re, mem_raddr[1:0]  out  RF read port; mem_rdata[72:0]  in, valid one cycle after mem_re.
REQ-014 pgcb_isol_en  out  1  RF isolation, 1 = isolated.
REQ-015 pwr_enable_b_in  out  1  RF power enable, active-low; pwr_enable_b_out  in  1  RF power-chain echo.
REQ-016 pwr_on  out  1  status, 1 only in state ON.

Function
REQ-017 FSM states: OFF, PUP (power up), ISO_REL (isolation release), ON, PDN (power down).
REQ-018 OFF: pwr_enable_b_in=1, pgcb_isol_en=1, req_ready=0; req_v=1 -> PUP.
REQ-019 PUP: pwr_enable_b_in=0, pgcb_isol_en=1; pwr_enable_b_out==0 -> ISO_REL.
REQ-020 ISO_REL: pgcb_isol_en=0 for exactly one cycle, then ON.
REQ-021 ON: req_ready=1; an accepted request at cycle T drives mem_* registered at T+1; a read returns rd_v/rd_data registered at T+3.
REQ-022 Writes and reads are issued in acceptance order; write followed by read of same address on the next accepted cycle returns the new data.
REQ-023 Idle counter (8 bits) clears on any accepted request or while any read is in flight; increments otherwise in ON; saturates at IDLE_TIMEOUT-1.
REQ-024 ON -> PDN when counter == IDLE_TIMEOUT-1, cfg_pg_en=1, req_v=0 and no read in flight; req_v=1 in that cycle is accepted and blocks the transition.
REQ-025 PDN: first cycle pgcb_isol_en=1 with pwr_enable_b_in=0; from the next cycle pwr_enable_b_in=1; pwr_enable_b_out==1 -> OFF.
REQ-026 PDN is never aborted; req_v during PDN waits (req_ready=0) and triggers PUP from OFF.
REQ-027 cfg_pg_en falling in ON stops power-down; falling in PDN does not abort.
REQ-028 RF contents are undefined after OFF; the block does not save/restore data.
REQ-029 mem_we and mem_re are never both 1 in the same cycle.

Reset
REQ-030 rst_n low forces OFF, pwr_enable_b_in=1, pgcb_isol_en=1, req_ready=0, pwr_on=0, rd_v=0, rd_data=0, rd_par_err=0, mem_we=0, mem_re=0, mem addresses/data=0, idle counter=0.
REQ-031 Reset mid-read discards the in-flight read; no rd_v after reset release.

Configuration
REQ-032 Macro HQM_LIST_SEL_RF_PG_CTRL_PAR_EN defined: mem_wdata[72]=even parity of req_wdata; on read rd_par_err = XOR of mem_rdata[72:0].
REQ-033 Macro undefined: mem_wdata[72]=0, rd_par_err tied 0; all other behaviour identical.

Structure
REQ-034 Shared package hqm_list_sel_rf_pg_pkg holds the FSM state enum, RF depth/address/data width constants (4, 2, 72, 73).
REQ-035 One sub-module hqm_list_sel_rf_pg_seq implements the power FSM and idle counter; the top holds request/response pipeline and parity.

Verification
REQ-036 Reset release, req_v=1 write addr 1 data 72'h5A -> PUP, echo after 3 cycles -> ISO_REL 1 cycle -> ON, req_ready=1, mem_we=1 addr 1 next cycle.
REQ-037 In ON, write addr 2 72'hABC then read addr 2 back-to-back -> rd_v 3 cycles after read acceptance, rd_data=72'hABC, rd_par_err=0.
REQ-038 cfg_pg_en=1, IDLE_TIMEOUT=16, no requests -> PDN entered after 16 idle cycles, isol before power-off, OFF after echo=1.
REQ-039 req_v=1 during PDN -> req_ready=0 through OFF, PUP, ISO_REL; accepted first cycle of ON.
REQ-040 PAR_EN build, force mem_rdata[0] flip on read of 72'h1 -> rd_v=1 with rd_par_err=1.
REQ-041 rst_n asserted one cycle after read acceptance -> all outputs at reset values, no rd_v after release.
